// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: show-ahead command FIFO that sits in front of an ALU.
// Each entry holds {opcode, operand A, operand B}. Illegal opcodes are
// accepted and dropped, and they raise a one-cycle err_illegal pulse.
// The head entry is presented combinationally, together with a one-hot
// select vector for the ALU result mux. All head outputs read zero while
// the FIFO is empty.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_op,
  output logic [WIDTH-1:0]         out_a,
  output logic [WIDTH-1:0]         out_b,
  output logic [11:0]              out_sel,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_NOT   = 4'b0010,
    OP_XOR   = 4'b0011,
    OP_NAND  = 4'b0100,
    OP_NOR   = 4'b0101,
    OP_XNOR  = 4'b0110,
    OP_ADD   = 4'b1000,
    OP_SUB   = 4'b1001,
    OP_SHR   = 4'b1010,
    OP_SHL   = 4'b1011,
    OP_CLEAR = 4'b1111
  } op_e;

  logic [3:0]       op_mem [DEPTH];
  logic [WIDTH-1:0] a_mem  [DEPTH];
  logic [WIDTH-1:0] b_mem  [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_illegal_q, err_illegal_d;

  logic op_legal;
  logic accept;
  logic push;
  logic pop;

  // Classify the incoming opcode against the legal opcode set.
  always_comb begin
    op_legal = 1'b0;
    case (in_op)
      OP_AND, OP_OR, OP_NOT, OP_XOR, OP_NAND, OP_NOR, OP_XNOR,
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_CLEAR: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  // Handshakes and next-state for the pointers, the occupancy count and the error flag.
  always_comb begin
    in_ready      = (count_q != FULL_CNT);
    out_valid     = (count_q != '0);
    accept        = in_valid & in_ready;
    push          = accept & op_legal;
    pop           = out_valid & out_ready;
    err_illegal_d = accept & ~op_legal;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      err_illegal_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      err_illegal_q <= err_illegal_d;
    end
  end

  // Command storage. It is not reset because nothing reads it while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      op_mem[wr_ptr_q] <= in_op;
      a_mem[wr_ptr_q]  <= in_a;
      b_mem[wr_ptr_q]  <= in_b;
    end
  end

  // Show-ahead head view and one-hot select. Both are forced to zero while empty.
  always_comb begin
    out_op  = '0;
    out_a   = '0;
    out_b   = '0;
    out_sel = '0;
    if (out_valid) begin
      out_op = op_mem[rd_ptr_q];
      out_a  = a_mem[rd_ptr_q];
      out_b  = b_mem[rd_ptr_q];
      case (out_op)
        OP_AND:   out_sel[0]  = 1'b1;
        OP_OR:    out_sel[1]  = 1'b1;
        OP_NOT:   out_sel[2]  = 1'b1;
        OP_XOR:   out_sel[3]  = 1'b1;
        OP_NAND:  out_sel[4]  = 1'b1;
        OP_NOR:   out_sel[5]  = 1'b1;
        OP_XNOR:  out_sel[6]  = 1'b1;
        OP_ADD:   out_sel[7]  = 1'b1;
        OP_SUB:   out_sel[8]  = 1'b1;
        OP_SHR:   out_sel[9]  = 1'b1;
        OP_SHL:   out_sel[10] = 1'b1;
        OP_CLEAR: out_sel[11] = 1'b1;
        default:  out_sel     = '0;
      endcase
    end
  end

  assign count       = count_q;
  assign err_illegal = err_illegal_q;

endmodule

// File: tb/tb_alu_cmd_fifo.sv
// Directed testbench for alu_cmd_fifo with DEPTH=4 and WIDTH=16.
module tb_alu_cmd_fifo;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic [11:0] out_sel;
  logic [2:0]  count;
  logic        err_illegal;

  int unsigned n_vec;
  int unsigned n_err;

  alu_cmd_fifo #(.DEPTH(4), .WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op      (out_op),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_sel     (out_sel),
    .count       (count),
    .err_illegal (err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
  endtask

  logic [3:0]  fill_op  [5];
  logic [11:0] fill_sel [5];
  logic [3:0]  bad_op   [4];
  logic [15:0] exp_a;
  logic [3:0]  exp_op;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    fill_op  = '{4'h0, 4'h1, 4'h3, 4'h8, 4'h9};
    fill_sel = '{12'h001, 12'h002, 12'h008, 12'h080, 12'h100};
    bad_op   = '{4'h7, 4'hC, 4'hD, 4'hE};
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    flush = 1'b0; out_ready = 1'b0;

    // Reset state, checked before any clock edge
    #2;
    check("rst_count", 32'(count), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_sel", 32'(out_sel), 0);
    check("rst_out_op", 32'(out_op), 0);
    check("rst_err", 32'(err_illegal), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Single ADD command
    push_one(4'h8, 16'h0001, 16'h0001);
    check("add_out_valid", 32'(out_valid), 1);
    check("add_out_op", 32'(out_op), 32'h8);
    check("add_out_sel", 32'(out_sel), 32'h080);
    check("add_count", 32'(count), 1);
    check("add_out_a", 32'(out_a), 1);
    check("add_out_b", 32'(out_b), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("add_pop_count", 32'(count), 0);
    check("add_pop_valid", 32'(out_valid), 0);
    check("add_pop_op", 32'(out_op), 0);
    check("add_pop_a", 32'(out_a), 0);
    check("add_pop_sel", 32'(out_sel), 0);

    // Fill to full, hold the fifth command, then drain in order
    for (int i = 0; i < 4; i++) push_one(fill_op[i], 16'(i), 16'(i + 16));
    check("fill_count", 32'(count), 4);
    check("fill_in_ready", 32'(in_ready), 0);
    check("fill_head_sel", 32'(out_sel), 32'h001);
    in_valid = 1'b1; in_op = fill_op[4]; in_a = 16'd4; in_b = 16'd20;
    tick();
    check("fill_held_count", 32'(count), 4);
    out_ready = 1'b1;
    tick();
    check("full_pop_count", 32'(count), 3);
    check("full_pop_head", 32'(out_op), 32'h1);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("fifth_accept_count", 32'(count), 4);
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check("drain_op", 32'(out_op), 32'(fill_op[i]));
      check("drain_sel", 32'(out_sel), 32'(fill_sel[i]));
      check("drain_a", 32'(out_a), 32'(i));
      check("drain_b", 32'(out_b), 32'(i + 16));
      tick();
    end
    check("drain_count", 32'(count), 0);
    // out_ready while empty must not underflow
    tick();
    check("empty_pop_count", 32'(count), 0);
    check("empty_pop_valid", 32'(out_valid), 0);
    out_ready = 1'b0;

    // Illegal opcodes: dropped, with a one-cycle error pulse
    for (int i = 0; i < 4; i++) begin
      push_one(bad_op[i], 16'h1234, 16'h5678);
      check("illegal_err", 32'(err_illegal), 1);
      check("illegal_count", 32'(count), 0);
      check("illegal_in_ready", 32'(in_ready), 1);
      tick();
      check("illegal_err_clear", 32'(err_illegal), 0);
    end

    // Steady stream at count=2 for 8 cycles
    push_one(4'h2, 16'h0010, 16'h0000);
    push_one(4'h4, 16'h0011, 16'h0000);
    check("stream_pre_count", 32'(count), 2);
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_op = 4'h6; in_a = 16'(32'h20 + k); in_b = '0;
      out_ready = 1'b1;
      exp_a  = (k == 0) ? 16'h0010 : (k == 1) ? 16'h0011 : 16'(32'h20 + k - 2);
      exp_op = (k == 0) ? 4'h2 : (k == 1) ? 4'h4 : 4'h6;
      check("stream_head_a", 32'(out_a), 32'(exp_a));
      check("stream_head_op", 32'(out_op), 32'(exp_op));
      tick();
      check("stream_count", 32'(count), 2);
    end
    in_valid = 1'b0;
    check("stream_tail_a0", 32'(out_a), 32'h26);
    check("stream_tail_sel", 32'(out_sel), 32'h040);
    tick();
    check("stream_tail_a1", 32'(out_a), 32'h27);
    tick();
    out_ready = 1'b0;
    check("stream_end_count", 32'(count), 0);

    // Flush at count=3 with a simultaneous push and pop
    push_one(4'hA, 16'h0001, 16'h0000);
    push_one(4'hB, 16'h0002, 16'h0000);
    push_one(4'hF, 16'h0003, 16'h0000);
    check("flush_pre_count", 32'(count), 3);
    flush = 1'b1; in_valid = 1'b1; in_op = 4'h8; in_a = 16'h0099; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_count", 32'(count), 0);
    check("flush_out_valid", 32'(out_valid), 0);
    check("flush_out_sel", 32'(out_sel), 0);
    check("flush_out_op", 32'(out_op), 0);
    // Illegal opcode together with flush still reports the error
    flush = 1'b1;
    push_one(4'hD, 16'h0000, 16'h0000);
    flush = 1'b0;
    check("flush_illegal_err", 32'(err_illegal), 1);
    check("flush_illegal_count", 32'(count), 0);
    push_one(4'hF, 16'h0055, 16'h00AA);
    check("post_flush_a", 32'(out_a), 32'h55);
    check("post_flush_sel", 32'(out_sel), 32'h800);
    check("post_flush_count", 32'(count), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset asserted mid-run at count=2
    push_one(4'h0, 16'h0001, 16'h0000);
    push_one(4'h1, 16'h0002, 16'h0000);
    check("mid_pre_count", 32'(count), 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_ready", 32'(in_ready), 1);
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_sel", 32'(out_sel), 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    push_one(4'hB, 16'h4002, 16'h0000);
    check("post_rst_a", 32'(out_a), 32'h4002);
    check("post_rst_sel", 32'(out_sel), 32'h400);
    check("post_rst_op", 32'(out_op), 32'hB);
    check("post_rst_count", 32'(count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_cmd_fifo.md
ALU_CMD_FIFO -- requirements
Module: alu_cmd_fifo

Interface
REQ-001 Parameter DEPTH, default 4, number of command entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter WIDTH, default 16, operand width in bits.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  upstream command present.
REQ-006 in_ready  output  1  FIFO can accept a command this cycle.
REQ-007 in_op  input  4  opcode.
REQ-008 in_a, in_b  input  WIDTH each  operands A and B.
REQ-009 flush  input  1  synchronous clear of all queued commands.
REQ-010 out_valid  output  1  head command available to the ALU.
REQ-011 out_ready  input  1  ALU consumes the head command this cycle.
REQ-012 out_op  output  4  head opcode.
REQ-013 out_a, out_b  output  WIDTH each  head operands.
REQ-014 out_sel  output  12  one-hot decode of out_op for the ALU result mux.
REQ-015 count  output  $clog2(DEPTH)+1  number of stored commands.
REQ-016 err_illegal  output  1  one-cycle pulse flagging a dropped illegal opcode.

Function
REQ-017 Legal opcodes SHALL be: AND 0000, OR 0001, NOT 0010, XOR 0011, NAND 0100, NOR 0101, XNOR 0110, ADD 1000, SUB 1001, SHR 1010, SHL 1011, CLEAR 1111.
REQ-018 Illegal opcodes SHALL be 0111, 1100, 1101 and 1110.
REQ-019 in_ready SHALL equal (count != DEPTH).
REQ-020 A push SHALL occur when in_valid, in_ready and a legal in_op are all high on a clock edge; it stores {in_op, in_a, in_b} at the write pointer.
REQ-021 An illegal in_op with in_valid and in_ready high SHALL complete the handshake, store nothing, and assert err_illegal for exactly the following cycle.
REQ-022 A pop SHALL occur when out_valid and out_ready are both high on a clock edge; it advances the read pointer.
REQ-023 out_valid SHALL equal (count != 0).
REQ-024 The head entry SHALL be show-ahead: out_op, out_a and out_b reflect the oldest entry combinationally from storage.
REQ-025 out_op, out_a, out_b and out_sel SHALL be all zero when the FIFO is empty.
REQ-026 out_sel SHALL map opcodes as follows: AND bit0, OR bit1, NOT bit2, XOR bit3, NAND bit4, NOR bit5, XNOR bit6, ADD bit7, SUB bit8, SHR bit9, SHL bit10, CLEAR bit11.
REQ-027 Latency SHALL be one cycle: a command pushed at edge N is visible with out_valid high after edge N; there is no same-cycle bypass while empty.
REQ-028 A simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-029 When full, push SHALL be blocked (in_ready low) even if a pop occurs in the same cycle; the pop proceeds.
REQ-030 When empty, out_ready SHALL be ignored.
REQ-031 Read and write pointers SHALL wrap modulo DEPTH.
REQ-032 count SHALL never exceed DEPTH nor underflow below 0.
REQ-033 flush SHALL take priority over a simultaneous push and pop: after the edge, count is 0 and the pointers are 0.
REQ-034 err_illegal SHALL still pulse for an illegal opcode presented in the same cycle as flush.
REQ-035 Order SHALL be preserved: commands leave in the order they were pushed.

Reset
REQ-036 While rst_n is low, without waiting for a clock, count, the pointers and err_illegal SHALL be 0, out_valid SHALL be 0, in_ready SHALL be 1, and out_op, out_a, out_b and out_sel SHALL be 0.
REQ-037 Storage contents are not reset and SHALL never be visible while empty.
REQ-038 Reset asserted mid-operation SHALL discard all queued commands; the first command after reset release SHALL be written at entry 0.
REQ-039 Reset deassertion SHALL take effect at the next rising edge of clk.

Verification
REQ-040 Single command: push ADD, a=0x0001, b=0x0001 -> next cycle out_valid=1, out_op=1000, out_sel=0x080, count=1; pop with out_ready=1 -> count=0 and outputs return to zero.
REQ-041 Fill, then drain: push 5 commands with out_ready=0 and DEPTH=4 -> the first 4 are accepted, in_ready=0 at count=4, the 5th is held until a pop frees space; the drain returns the opcodes in push order.
REQ-042 Illegal opcode: push op=1100 -> count unchanged, err_illegal=1 for exactly one cycle, in_ready stays 1.
REQ-043 Steady stream: continuous push and pop at count=2 for 8 cycles -> count stays 2, pointers wrap, and no command is lost or duplicated.
REQ-044 Flush: flush=1 at count=3 with simultaneous push and pop -> next cycle count=0, out_valid=0, out_sel=0.
REQ-045 Reset mid-run: rst_n low at count=2 -> out_valid=0 and in_ready=1 immediately; after release, a push of SHL with a=0x4002 -> out_a=0x4002, out_sel=0x400.
